// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the master controller and this responder.
package spi_pkg;

    localparam int unsigned SPI_WIDTH     = 8;
    localparam logic        SPI_MISO_IDLE = 1'b1;
    localparam logic        SPI_FILL_BIT  = 1'b1;
    localparam logic        SPI_CPOL      = 1'b0;
    localparam logic        SPI_CPHA      = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_cont_if.sv
// Byte strobe/ack interfaces plus SPI pins of the responder.
interface spi_slave_cont_if
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
);
    logic             w_stb;
    logic [WIDTH-1:0] w_data;
    logic             w_ack;
    logic             r_stb;
    logic [WIDTH-1:0] r_data;
    logic             r_ack;
    logic             r_ovr;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             ss_n;

    modport slave (
        input  w_stb, w_data, r_ack, sclk, mosi, ss_n,
        output w_ack, r_stb, r_data, r_ovr, miso
    );

    modport master (
        output w_stb, w_data, r_ack, sclk, mosi, ss_n,
        input  w_ack, r_stb, r_data, r_ovr, miso
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer; one channel also yields registered rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned W        = 1,
    parameter logic        EDGE_RST = 1'b0,
    parameter logic [W-1:0] DATA_RST = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         edge_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         rise_o,
    output logic         fall_o
);
    logic [W:0] sync_q [STAGES];
    logic       prev_q;
    logic       rise_q;
    logic       fall_q;
    logic       edge_s;

    assign edge_s = sync_q[STAGES-1][0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= {DATA_RST, EDGE_RST};
            prev_q <= EDGE_RST;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= {data_i, edge_i};
            for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev_q <= edge_s;
            rise_q <= edge_s & ~prev_q;
            fall_q <= ~edge_s & prev_q;
        end
    end

    assign data_o = sync_q[STAGES-1][W:1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_cont.sv
// Mode-0 SPI responder: oversampled pins, holding register for MISO bytes,
// strobe/ack byte delivery with overrun flag.
module spi_slave_cont
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             in_sclk_i,
    input logic             rst_ni,
    spi_slave_cont_if.slave bus
);
    localparam int unsigned      CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_PRE  = CW'(WIDTH - 1);
    localparam logic             SAMPLE_ON_RISE = ~(SPI_CPOL ^ SPI_CPHA);
    localparam logic [WIDTH-1:0] FILL     = {WIDTH{SPI_FILL_BIT}};

    logic ss_s, mosi_s, sclk_rise, sclk_fall, sample_p, launch_p, load;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .W       (2),
        .EDGE_RST(SPI_CPOL),
        .DATA_RST(2'b10)
    ) u_sync (
        .clk_i (in_sclk_i),
        .rst_ni(rst_ni),
        .edge_i(bus.sclk),
        .data_i({bus.ss_n, bus.mosi}),
        .data_o({ss_s, mosi_s}),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    assign sample_p = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign launch_p = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, hold_q, hold_d, r_data_q, r_data_d;
    logic             hold_full_q, hold_full_d;
    logic             w_ack_q, w_ack_d, r_stb_q, r_stb_d, r_ovr_q, r_ovr_d, miso_q, miso_d;

    always_ff @(posedge in_sclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            tx_q        <= FILL;
            rx_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            r_data_q    <= '0;
            w_ack_q     <= 1'b0;
            r_stb_q     <= 1'b0;
            r_ovr_q     <= 1'b0;
            miso_q      <= SPI_MISO_IDLE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            r_data_q    <= r_data_d;
            w_ack_q     <= w_ack_d;
            r_stb_q     <= r_stb_d;
            r_ovr_q     <= r_ovr_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = ss_s ? ST_IDLE : ST_SHIFT;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        r_data_d    = r_data_q;
        w_ack_d     = 1'b0;
        r_stb_d     = r_stb_q;
        r_ovr_d     = 1'b0;
        load        = 1'b0;

        if (bus.w_stb && !hold_full_q) begin
            hold_d      = bus.w_data;
            hold_full_d = 1'b1;
            w_ack_d     = 1'b1;
        end
        if (bus.r_ack && r_stb_q) r_stb_d = 1'b0;

        if (state_q == ST_SHIFT) begin
            if (ss_s) begin
                // Deselect mid-byte drops the partial byte; an untouched loaded byte survives.
                cnt_d = '0;
                rx_d  = '0;
                if (cnt_q != '0) begin
                    tx_d     = FILL;
                    loaded_d = 1'b0;
                end
            end else begin
                if (cnt_q == '0 && !loaded_q) load = 1'b1;
                if (sample_p && cnt_q < CNT_LAST) begin
                    rx_d  = {rx_q[WIDTH-2:0], mosi_s};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_PRE) begin
                        r_data_d = {rx_q[WIDTH-2:0], mosi_s};
                        r_stb_d  = 1'b1;
                        r_ovr_d  = r_stb_q && !bus.r_ack;
                    end
                end else if (launch_p && cnt_q != '0) begin
                    tx_d = {tx_q[WIDTH-2:0], SPI_FILL_BIT};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        load  = 1'b1;
                    end
                end
            end
        end

        // Byte boundary: next MISO byte comes from the holding register or underrun fill.
        if (load) begin
            loaded_d = 1'b1;
            if (hold_full_q) begin
                tx_d        = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_d = FILL;
            end
        end

        miso_d = ss_s ? SPI_MISO_IDLE : tx_d[WIDTH-1];
    end

    assign bus.w_ack  = w_ack_q;
    assign bus.r_stb  = r_stb_q;
    assign bus.r_data = r_data_q;
    assign bus.r_ovr  = r_ovr_q;
    assign bus.miso   = miso_q;
endmodule
